dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the single-cycle core: serves its load/store port (address, store data,
//  store size, load size). Combinational read so loads finish in the same cycle; stores commit on clk.
//  Holds a word-organised RAM plus an MMIO page (64-bit cycle counter, GPIO register, error status).
//  Rejects and reports misaligned and out-of-range accesses.
// PARAMETERS
//  DEPTH      1024          RAM size in 32-bit words; RAM spans 0 .. DEPTH*4-1
//  MMIO_BASE  32'h8000_0000 base of the 16-byte MMIO page
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  addr       in   32  byte address (core ALU result)
//  wdata      in   32  store data, right-aligned (byte/half in low bits)
//  mem_write  in   2   00 none, 01 byte, 10 half, 11 word store
//  size_load  in   3   load format = funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//  rdata      out  32  load data, extended per size_load
//  gpio_out   out  32  GPIO register value
//  err_irq    out  1   high while any error status bit is set
// BEHAVIOUR
//  Reset: gpio_out=0, err_irq=0, counter=0, cnt_hi_shadow=0, err status=0, err_addr=0.
//   RAM contents are not reset. rdata is combinational, so it has no reset value.
//  Decode: RAM if addr<DEPTH*4; MMIO if addr[31:4]==MMIO_BASE[31:4]; all other addresses are unmapped.
//  Read path (combinational, 0 latency): word=RAM[addr>>2] or MMIO reg; lane=addr[1:0].
//   lb/lbu: byte word[8*lane+:8], sign- or zero-extended.
//   lh/lhu: half word[16*addr[1]+:16], sign- or zero-extended.
//   lw and undefined codes (011,110,111): full word.
//   Unmapped or misaligned read: rdata=0. No error is flagged, because size_load is always driven.
//  Store (mem_write!=0), commits at rising clk:
//   byte: writes lane addr[1:0] only. half: lanes 2*addr[1]..+1. word: all 4 lanes.
//   Misaligned (half with addr[0]=1; word with addr[1:0]!=0): write suppressed, MISALIGN set, err_addr<=addr.
//   Unmapped: write dropped, RANGE set, err_addr<=addr.
//   MMIO accepts word stores only. A sub-word MMIO store is dropped and sets MISALIGN.
//  MMIO map (offset from MMIO_BASE):
//   +0x0 CNT_LO  RO  counter[31:0]. At the clk edge where addr==CNT_LO and mem_write==0,
//                    cnt_hi_shadow<=counter[63:32] (value coherent with the LO read that cycle).
//   +0x4 CNT_HI  RO  returns cnt_hi_shadow. Writes to CNT_LO/CNT_HI are ignored with no error.
//   +0x8 GPIO    RW  gpio_out; updated the cycle after the store edge.
//   +0xC ERR     R/W1C bit0 MISALIGN, bit1 RANGE, bits31:2 read 0. err_addr is not readable here;
//                    it is a debug probe only.
//  Counter: 64-bit, +1 every clk, wraps 2^64-1 -> 0, never stalls.
//  err_irq = |err_status, registered, so it changes on the edge after the status update.
//  Simultaneous W1C to ERR and a new error in the same cycle: set wins for the new bit.
//   err_addr records the most recent error; a later error overwrites it.
//  Reset mid-operation: asynchronous clear of all registers. A store in flight at reset is lost.
//   RAM words already written keep their value.
// TESTING
//  1 sw 0xDEADBEEF @0x10, then lb/lbu/lh/lhu/lw @0x11 / 0x12 / 0x10 ->
//    0xFFFFFFBE / 0x000000BE / 0xFFFFDEAD / 0x0000DEAD / 0xDEADBEEF.
//  2 sb 0x55 @0x13 over word 0xDEADBEEF -> lw @0x10 = 0x55ADBEEF; lanes 0..2 unchanged.
//  3 sw @0x12 -> RAM unchanged, err_irq=1 next edge, ERR=1; sw 1 to ERR -> err_irq=0 after edge;
//    sh @0x21 -> ERR=1 again.
//  4 sw @DEPTH*4 -> dropped, ERR=2; lw from the same address -> 0.
//    W1C to ERR in the same cycle as a new RANGE error -> bit1 stays 1.
//  5 Force counter to 0x0000_0000_FFFF_FFFF; lw CNT_LO (reads 0xFFFFFFFF), lw CNT_HI next ->
//    0x00000000 (shadow, not the wrapped value 1); next CNT_LO/HI pair is coherent after the carry.
//  6 sw 0xA5A5A5A5 to GPIO -> gpio_out=0xA5A5A5A5 next edge;
//    assert reset mid-stream -> gpio_out=0, err_irq=0, counter=0 immediately, RAM data retained.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: combinational loads, clocked stores,
// word-organised RAM plus a 16-byte MMIO page (cycle counter, GPIO, sticky error status).
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  mem_write,
  input  logic [2:0]  size_load,
  output logic [31:0] rdata,
  output logic [31:0] gpio_out,
  output logic        err_irq,
  output logic [31:0] err_addr
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [27:0] MMIO_PAGE = MMIO_BASE[31:4];

  logic [31:0] r_mem [DEPTH];
  logic [63:0] r_counter;
  logic [31:0] r_cnt_hi;
  logic [31:0] r_gpio;
  logic [1:0]  r_err;
  logic [31:0] r_err_addr;
  logic        r_irq;

  logic          w_is_ram;
  logic          w_is_mmio;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_lane;
  logic          w_ld_byte;
  logic          w_ld_half;
  logic          w_ld_mis;
  logic          w_st_byte;
  logic          w_st_half;
  logic          w_st_word;
  logic          w_st_mis;
  logic          w_st_rng;
  logic          w_st_ok;
  logic          w_ram_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [1:0]    w_err_clr;

  assign w_is_ram  = (addr < RAM_BYTES);
  assign w_is_mmio = (addr[31:4] == MMIO_PAGE);
  assign w_idx     = addr[AW+1:2];

  // Load decode: funct3[1:0] selects width, funct3[2] selects zero-extension.
  assign w_ld_byte = (size_load[1:0] == 2'b00);
  assign w_ld_half = (size_load[1:0] == 2'b01);
  assign w_ld_mis  = (w_ld_half && addr[0]) ||
                     (!w_ld_byte && !w_ld_half && (addr[1:0] != 2'b00));

  always_comb begin
    w_word = '0;
    if (w_is_ram) begin
      w_word = r_mem[w_idx];
    end else if (w_is_mmio) begin
      case (addr[3:2])
        2'd0:    w_word = r_counter[31:0];
        2'd1:    w_word = r_cnt_hi;
        2'd2:    w_word = r_gpio;
        default: w_word = {30'b0, r_err};
      endcase
    end
  end

  assign w_lane = w_word >> {addr[1:0], 3'b000};

  always_comb begin
    rdata = '0;
    if ((w_is_ram || w_is_mmio) && !w_ld_mis) begin
      if (w_ld_byte)
        rdata = {{24{~size_load[2] & w_lane[7]}}, w_lane[7:0]};
      else if (w_ld_half)
        rdata = {{16{~size_load[2] & w_lane[15]}}, w_lane[15:0]};
      else
        rdata = w_lane;
    end
  end

  assign w_st_byte = (mem_write == 2'b01);
  assign w_st_half = (mem_write == 2'b10);
  assign w_st_word = (mem_write == 2'b11);
  // Alignment faults take priority over range faults; MMIO only takes whole words.
  assign w_st_mis  = (w_st_half && addr[0]) ||
                     (w_st_word && (addr[1:0] != 2'b00)) ||
                     (w_is_mmio && (w_st_byte || w_st_half));
  assign w_st_rng  = (mem_write != 2'b00) && !w_st_mis && !w_is_ram && !w_is_mmio;
  assign w_st_ok   = (mem_write != 2'b00) && !w_st_mis && !w_st_rng;
  assign w_ram_we  = w_st_ok && w_is_ram && reset;
  assign w_err_clr = (w_st_ok && w_is_mmio && (addr[3:2] == 2'd3)) ? wdata[1:0] : 2'b00;

  always_comb begin
    w_be = 4'b0000;
    w_wd = wdata;
    case (mem_write)
      2'b01: begin
        w_be = 4'b0001 << addr[1:0];
        w_wd = {4{wdata[7:0]}};
      end
      2'b10: begin
        w_be = addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{wdata[15:0]}};
      end
      2'b11: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM has no reset so stored data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_counter  <= '0;
      r_cnt_hi   <= '0;
      r_gpio     <= '0;
      r_err      <= '0;
      r_err_addr <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_counter <= r_counter + 64'd1;
      // Snapshot the high half with the low-half read so a LO/HI pair is coherent.
      if ((addr == MMIO_BASE) && (mem_write == 2'b00)) r_cnt_hi <= r_counter[63:32];
      if (w_st_ok && w_is_mmio && (addr[3:2] == 2'd2)) r_gpio <= wdata;
      r_err <= (r_err & ~w_err_clr) | {w_st_rng, w_st_mis};
      if (w_st_rng || w_st_mis) r_err_addr <= addr;
      r_irq <= |r_err;
    end
  end

  assign gpio_out = r_gpio;
  assign err_irq  = r_irq;
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic checked against a
// byte-addressed reference model of the RAM and MMIO page.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  mem_write = '0;
  logic [2:0]  size_load = 3'b010;
  logic [31:0] rdata;
  logic [31:0] gpio_out;
  logic        err_irq;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mb [int unsigned];
  logic [63:0] m_cnt;
  logic [31:0] m_shadow;
  logic [31:0] m_gpio;
  logic [31:0] m_eaddr;
  logic [1:0]  m_err;
  logic        m_irq;

  dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .size_load (size_load),
    .rdata     (rdata),
    .gpio_out  (gpio_out),
    .err_irq   (err_irq),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns 0 when the load touches RAM bytes the bench never wrote.
  function automatic bit model_read(input logic [31:0] a, input logic [2:0] sl,
                                    output logic [31:0] v);
    int unsigned n;
    logic [31:0] w;
    bit ram, mm;
    n   = (sl == 3'b000 || sl == 3'b100) ? 1 : (sl == 3'b001 || sl == 3'b101) ? 2 : 4;
    ram = (a < DEPTH * 4);
    mm  = ((a >> 4) == (BASE >> 4));
    v   = '0;
    w   = '0;
    if (!(ram || mm) || (a % n) != 0) return 1'b1;
    if (ram) begin
      for (int i = 0; i < int'(n); i++) begin
        if (!mb.exists(a + i)) return 1'b0;
        w = w | (32'(mb[a + i]) << (8 * i));
      end
    end else begin
      case ((a - BASE) & 32'hC)
        32'h0:   w = m_cnt[31:0];
        32'h4:   w = m_shadow;
        32'h8:   w = m_gpio;
        default: w = {30'b0, m_err};
      endcase
      w = w >> (8 * (a % 4));
    end
    if (n == 1)      v = (sl == 3'b000) ? {{24{w[7]}}, w[7:0]} : {24'b0, w[7:0]};
    else if (n == 2) v = (sl == 3'b001) ? {{16{w[15]}}, w[15:0]} : {16'b0, w[15:0]};
    else             v = w;
    return 1'b1;
  endfunction

  task automatic model_update(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] mw);
    int unsigned n;
    bit ram, mm, irq_next;
    n        = (mw == 2'b01) ? 1 : (mw == 2'b10) ? 2 : 4;
    ram      = (a < DEPTH * 4);
    mm       = ((a >> 4) == (BASE >> 4));
    irq_next = (m_err != 2'b00);
    if (a == BASE && mw == 2'b00) m_shadow = m_cnt[63:32];
    m_cnt = m_cnt + 1;
    if (mw != 2'b00) begin
      if ((a % n) != 0 || (mm && n != 4)) begin
        m_err[0] = 1'b1;
        m_eaddr  = a;
      end else if (!ram && !mm) begin
        m_err[1] = 1'b1;
        m_eaddr  = a;
      end else if (ram) begin
        for (int i = 0; i < int'(n); i++) mb[a + i] = wd[8*i +: 8];
      end else if ((a - BASE) == 32'h8) begin
        m_gpio = wd;
      end else if ((a - BASE) == 32'hC) begin
        m_err = m_err & ~wd[1:0];
      end
    end
    m_irq = irq_next;
  endtask

  task automatic model_reset();
    m_cnt    = '0;
    m_shadow = '0;
    m_gpio   = '0;
    m_eaddr  = '0;
    m_err    = '0;
    m_irq    = 1'b0;
  endtask

  task automatic drive_check(input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] mw, input logic [2:0] sl);
    logic [31:0] v;
    addr      = a;
    wdata     = wd;
    mem_write = mw;
    size_load = sl;
    #1;
    if (model_read(a, sl, v)) check("rdata", rdata, v);
  endtask

  task automatic edge_phase(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] mw);
    @(posedge clk);
    model_update(a, wd, mw);
    #1;
    check("gpio_out", gpio_out, m_gpio);
    check("err_irq", {31'b0, err_irq}, {31'b0, m_irq});
    check("err_addr", err_addr, m_eaddr);
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] mw, input logic [2:0] sl);
    @(negedge clk);
    drive_check(a, wd, mw, sl);
    edge_phase(a, wd, mw);
  endtask

  task automatic ld_exp(input string tag, input logic [31:0] a, input logic [2:0] sl,
                        input logic [31:0] exp);
    @(negedge clk);
    drive_check(a, '0, 2'b00, sl);
    check(tag, rdata, exp);
    edge_phase(a, '0, 2'b00);
  endtask

  // Async reset mid-cycle with a word store pending to 0x10 that must be lost.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset     = 1'b0;
    addr      = BASE;
    mem_write = 2'b00;
    size_load = 3'b010;
    #1;
    model_reset();
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_irq", {31'b0, err_irq}, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_cnt_lo", rdata, 32'h0);
    addr      = 32'h10;
    wdata     = 32'h0;
    mem_write = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    addr      = '0;
    mem_write = 2'b00;
    edge_phase('0, '0, 2'b00);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_gpio", gpio_out, 32'h0);
    check("init_irq", {31'b0, err_irq}, 32'h0);
    check("init_cnt_lo", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    edge_phase('0, '0, 2'b00);

    // Loads of every width from one stored word.
    cyc(32'h10, 32'hDEAD_BEEF, 2'b11, 3'b010);
    ld_exp("t1_lb",  32'h11, 3'b000, 32'hFFFF_FFBE);
    ld_exp("t1_lbu", 32'h11, 3'b100, 32'h0000_00BE);
    ld_exp("t1_lh",  32'h12, 3'b001, 32'hFFFF_DEAD);
    ld_exp("t1_lhu", 32'h12, 3'b101, 32'h0000_DEAD);
    ld_exp("t1_lw",  32'h10, 3'b010, 32'hDEAD_BEEF);

    cyc(32'h13, 32'h0000_0055, 2'b01, 3'b010);
    ld_exp("t2_lw", 32'h10, 3'b010, 32'h55AD_BEEF);

    cyc(32'h12, 32'h1234_5678, 2'b11, 3'b010);
    ld_exp("t3_ram", 32'h10, 3'b010, 32'h55AD_BEEF);
    ld_exp("t3_err", BASE + 32'hC, 3'b010, 32'h1);
    check("t3_irq", {31'b0, err_irq}, 32'h1);
    check("t3_eaddr", err_addr, 32'h12);
    cyc(BASE + 32'hC, 32'h1, 2'b11, 3'b010);
    cyc(32'h0, 32'h0, 2'b00, 3'b010);
    check("t3_irq_clr", {31'b0, err_irq}, 32'h0);
    cyc(32'h21, 32'hFFFF, 2'b10, 3'b010);
    ld_exp("t3_sh_err", BASE + 32'hC, 3'b010, 32'h1);

    cyc(BASE + 32'hC, 32'h3, 2'b11, 3'b010);
    cyc(DEPTH * 4, 32'hCAFE_F00D, 2'b11, 3'b010);
    ld_exp("t4_err", BASE + 32'hC, 3'b010, 32'h2);
    ld_exp("t4_lw_oob", DEPTH * 4, 3'b010, 32'h0);
    cyc(BASE + 32'h8, 32'h1234_5678, 2'b01, 3'b010);
    ld_exp("t4_mmio_sb", BASE + 32'hC, 3'b010, 32'h3);
    cyc(BASE + 32'hC, 32'h3, 2'b11, 3'b010);

    cyc(BASE + 32'h8, 32'hA5A5_A5A5, 2'b11, 3'b010);
    check("t6_gpio", gpio_out, 32'hA5A5_A5A5);
    cyc(BASE, 32'h1111_1111, 2'b11, 3'b010);
    ld_exp("t6_gpio_rd", BASE + 32'h8, 3'b010, 32'hA5A5_A5A5);

    // Counter carry across the 32-bit boundary and shadow coherence.
    @(negedge clk);
    force dut.r_counter = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.r_counter;
    m_cnt = 64'h0000_0000_FFFF_FFFF;
    drive_check(BASE, '0, 2'b00, 3'b010);
    check("t5_lo1", rdata, 32'hFFFF_FFFF);
    edge_phase(BASE, '0, 2'b00);
    ld_exp("t5_hi1", BASE + 32'h4, 3'b010, 32'h0);
    ld_exp("t5_lo2", BASE, 3'b010, 32'h1);
    ld_exp("t5_hi2", BASE + 32'h4, 3'b010, 32'h1);

    do_reset();
    check("t6_rst_gpio", gpio_out, 32'h0);
    ld_exp("t6_ram_kept", 32'h10, 3'b010, 32'h55AD_BEEF);

    for (int k = 0; k < 600; k++) begin
      int unsigned sel;
      logic [31:0] a;
      logic [1:0]  mw;
      sel = $urandom_range(0, 99);
      if (sel < 55)      a = $urandom_range(0, 63);
      else if (sel < 70) a = BASE + $urandom_range(0, 15);
      else if (sel < 80) a = DEPTH * 4 + $urandom_range(0, 31);
      else if (sel < 92) a = $urandom_range(0, DEPTH * 4 - 1);
      else               a = $urandom;
      mw = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      cyc(a, $urandom, mw, 3'($urandom_range(0, 7)));
    end

    do_reset();
    for (int k = 0; k < 16; k++) cyc(32'(k * 4), '0, 2'b00, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
